alu_issue_stage: RTL

//  Decode/issue stage upstream of the ALU: decodes an RV32I instruction plus register-file values into
//  OP_1/OP_2/ALU_FUN and hands them to the execute stage. One registered pipeline stage on a

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_issue_skid.sv | 93 +++++++++
 rtl/alu_issue_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU function codes, RV32I opcodes
// and the issue_t entry carried through the skid buffer.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [3:0]  alu_fun;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } issue_t;

    // alt selects the SUB/SRA variant (instruction bit 30)
    function automatic logic [3:0] alu_fun_of(input logic alt, input logic [2:0] funct3);
        logic [3:0] fun;
        fun = ALU_ADD;
        case (funct3)
            3'b000:  fun = alt ? ALU_SUB : ALU_ADD;
            3'b001:  fun = ALU_SLL;
            3'b010:  fun = ALU_SLT;
            3'b011:  fun = ALU_SLTU;
            3'b100:  fun = ALU_XOR;
            3'b101:  fun = alt ? ALU_SRA : ALU_SRL;
            3'b110:  fun = ALU_OR;
            default: fun = ALU_AND;
        endcase
        return fun;
    endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry skid buffer of issue_t: main register drives the output, skid register
// absorbs the one extra entry accepted while in_ready is still high.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid=0
// ST_BUSY  | main holds an entry, skid empty
// ST_FULL  | main and skid both hold entries, in_ready=0
module alu_issue_skid
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   in_valid,
    output logic   in_ready,
    input  issue_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output issue_t out_data
);

    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} skid_state_t;

    skid_state_t state, state_nxt;
    issue_t      main_q, skid_q;
    logic        in_ready_q;
    logic        push, pop;
    logic        main_ld, main_from_skid, skid_ld;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt = ST_BUSY;
                    main_ld   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (push && !pop) begin
                    state_nxt = ST_FULL;
                    skid_ld   = 1'b1;
                end else if (pop && !push) begin
                    state_nxt = ST_EMPTY;
                end else if (push && pop) begin
                    main_ld = 1'b1;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_nxt      = ST_BUSY;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Held data is left as is on flush; out_valid hides it.
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_ld   = 1'b0;
            skid_ld   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
            if (main_ld) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (skid_ld) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the ALU through a registered skid buffer.
// Define ALU_ISSUE_ILLEGAL_EN to issue illegal entries flagged on out_illegal instead of dropping them.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op_1,
    output logic [XLEN-1:0] out_op_2,
    output logic [3:0]      out_alu_fun,
    output logic [4:0]      out_rd,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic            out_illegal,
`endif
    output logic            out_we
);

    if (XLEN != 32 || RESET_PC != 32'h0) begin : g_param_check
        $error("alu_issue_stage supports only XLEN=32 and RESET_PC=0");
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_u;
    logic        op_legal;
    issue_t      dec, skid_out;
    logic        skid_in_valid;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u  = {in_instr[31:12], 12'b0};

    assign op_legal = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        dec         = '0;
        dec.alu_fun = ALU_ADD;
        dec.rd      = in_instr[11:7];
        case (opcode)
            OPC_OP: begin
                if (op_legal) begin
                    dec.op_1    = in_rs1;
                    dec.op_2    = in_rs2;
                    dec.alu_fun = alu_fun_of(in_instr[30], funct3);
                    dec.we      = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // bit 30 is immediate data except for the shift-right pair
                dec.op_1    = in_rs1;
                dec.op_2    = imm_i;
                dec.alu_fun = alu_fun_of((funct3 == 3'b101) && in_instr[30], funct3);
                dec.we      = 1'b1;
            end
            OPC_LUI: begin
                dec.op_1    = imm_u;
                dec.alu_fun = ALU_LUI;
                dec.we      = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_1 = imm_u;
                dec.op_2 = in_pc;
                dec.we   = 1'b1;
            end
            OPC_LOAD: begin
                dec.op_1 = in_rs1;
                dec.op_2 = imm_i;
                dec.we   = 1'b1;
            end
            OPC_STORE: begin
                dec.op_1 = in_rs1;
                dec.op_2 = imm_s;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign skid_in_valid = in_valid;
    assign out_illegal   = skid_out.illegal;
`else
    // Illegal words are still accepted upstream, they just never enter the buffer.
    logic unused_illegal;
    assign skid_in_valid  = in_valid & ~dec.illegal;
    assign unused_illegal = skid_out.illegal;
`endif

    alu_issue_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (skid_in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

    assign out_op_1    = skid_out.op_1;
    assign out_op_2    = skid_out.op_2;
    assign out_alu_fun = skid_out.alu_fun;
    assign out_rd      = skid_out.rd;
    assign out_we      = skid_out.we;

endmodule
